// File: rtl/idiv_iter_pkg.sv
// Shared definitions for the iterative radix-2 restoring divider.
package idiv_iter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam int XLEN_DEFAULT = 64;

  function automatic int cnt_width(input int xlen);
    return $clog2(xlen);
  endfunction

endpackage

// File: rtl/idiv_iter_if.sv
// Execute-stage launch/result bundle between the datapath and the divider.
interface idiv_iter_if #(
  parameter int XLEN = 64
);
  logic            StartE;
  logic            FlushE;
  logic [XLEN-1:0] ForwardedSrcAE;
  logic [XLEN-1:0] ForwardedSrcBE;
  logic [2:0]      Funct3E;
  logic            W64E;
  logic            BusyE;
  logic            DoneE;
  logic [XLEN-1:0] DivResult;

  modport master (
    output StartE, FlushE, ForwardedSrcAE, ForwardedSrcBE, Funct3E, W64E,
    input  BusyE, DoneE, DivResult
  );

  modport slave (
    input  StartE, FlushE, ForwardedSrcAE, ForwardedSrcBE, Funct3E, W64E,
    output BusyE, DoneE, DivResult
  );
endinterface

// File: rtl/idiv_iter_step.sv
// One restoring shift-subtract iteration on {P,Q}; combinational.
module idiv_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] p_i,
  input  logic [XLEN-1:0] q_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] p_o,
  output logic [XLEN-1:0] q_o
);

  logic [XLEN:0] ps;
  logic [XLEN:0] t;

  // XLEN+1 bits keep the borrow meaningful for an unsigned divisor with its msb set
  always_comb begin
    ps  = {p_i, q_i[XLEN-1]};
    t   = ps - {1'b0, b_i};
    p_o = t[XLEN] ? ps[XLEN-1:0] : t[XLEN-1:0];
    q_o = {q_i[XLEN-2:0], ~t[XLEN]};
  end

endmodule

// File: rtl/idiv_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and W variants.
module idiv_iter
  import idiv_iter_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input logic        clk,
  input logic        reset,
  idiv_iter_if.slave bus
);

  localparam int CW = cnt_width(XLEN);
  localparam logic [XLEN-1:0] MOSTNEG   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MOSTNEG_W = ~XLEN'(32'h7FFF_FFFF);

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] p_q, q_q, b_q, res_q;
  logic            negq_q, negr_q, rem_q, w_q, done_q;

  logic            wop, sgn, rem, a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, spec_p, spec_q;
  logic [XLEN-1:0] p_nx, q_nx;

  function automatic logic [XLEN-1:0] finish_res(
    input logic [XLEN-1:0] p, q,
    input logic r, nq, nr, w
  );
    logic [XLEN-1:0] v;
    v = r ? (nr ? -p : p) : (nq ? -q : q);
    if (w) v = XLEN'(signed'(v[31:0]));
    return v;
  endfunction

  always_comb begin
    wop   = (XLEN == 64) && bus.W64E;
    sgn   = (bus.Funct3E == F3_DIV) || (bus.Funct3E == F3_REM);
    rem   = (bus.Funct3E == F3_REM) || (bus.Funct3E == F3_REMU);
    a_ext = bus.ForwardedSrcAE;
    b_ext = bus.ForwardedSrcBE;
    if (wop) begin
      a_ext = sgn ? XLEN'(signed'(bus.ForwardedSrcAE[31:0])) : XLEN'(bus.ForwardedSrcAE[31:0]);
      b_ext = sgn ? XLEN'(signed'(bus.ForwardedSrcBE[31:0])) : XLEN'(bus.ForwardedSrcBE[31:0]);
    end
    a_neg  = sgn & a_ext[XLEN-1];
    b_neg  = sgn & b_ext[XLEN-1];
    abs_a  = a_neg ? -a_ext : a_ext;
    abs_b  = b_neg ? -b_ext : b_ext;
    div0   = (b_ext == '0);
    ovf    = sgn && (a_ext == (wop ? MOSTNEG_W : MOSTNEG)) && (b_ext == '1);
    spec_p = div0 ? a_ext : '0;
    spec_q = div0 ? '1 : a_ext;
  end

  idiv_step #(.XLEN(XLEN)) u_step (
    .p_i(p_q),
    .q_i(q_q),
    .b_i(b_q),
    .p_o(p_nx),
    .q_o(q_nx)
  );

  // Result is registered on the edge entering DONE so it is valid alongside DoneE.
  // A W operand is left-aligned in Q so 32 shifts consume exactly its bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      rem_q   <= 1'b0;
      w_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.StartE && !bus.FlushE) begin
            rem_q <= rem;
            w_q   <= wop;
            if (div0 || ovf) begin
              res_q   <= finish_res(spec_p, spec_q, rem, 1'b0, 1'b0, wop);
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              p_q     <= '0;
              q_q     <= wop ? (abs_a << 32) : abs_a;
              b_q     <= abs_b;
              negq_q  <= a_neg ^ b_neg;
              negr_q  <= a_neg;
              cnt_q   <= wop ? CW'(31) : CW'(XLEN-1);
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus.FlushE) begin
            state_q <= IDLE;
          end else begin
            p_q <= p_nx;
            q_q <= q_nx;
            if (cnt_q == '0) begin
              res_q   <= finish_res(p_nx, q_nx, rem_q, negq_q, negr_q, w_q);
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // A flush landing in the DONE cycle suppresses the completion pulse.
  assign bus.DoneE     = done_q & ~bus.FlushE;
  assign bus.BusyE     = (bus.StartE && (state_q == IDLE) && !bus.FlushE) || (state_q == BUSY);
  assign bus.DivResult = res_q;

endmodule

// File: tb/tb_idiv_iter.sv
// Self-checking bench for idiv_iter: directed cases, flush/reset aborts, random ops vs a plain-arithmetic model.
module tb_idiv_iter;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;
  logic [63:0] last_res;

  idiv_iter_if #(.XLEN(64)) bus ();

  idiv_iter #(.XLEN(64)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics computed directly with SV arithmetic.
  function automatic logic [63:0] model(input logic [63:0] a, b, input logic [2:0] f3, input logic w);
    logic        sgn, rem;
    logic [31:0] a32, b32, r32;
    logic [63:0] r64;
    sgn = ~f3[0];
    rem = f3[1];
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 32'd0)                                            r32 = rem ? a32 : 32'hFFFF_FFFF;
      else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = rem ? 32'd0 : a32;
      else if (sgn && rem)                                         r32 = $signed(a32) % $signed(b32);
      else if (sgn)                                                r32 = $signed(a32) / $signed(b32);
      else if (rem)                                                r32 = a32 % b32;
      else                                                         r32 = a32 / b32;
      return {{32{r32[31]}}, r32};
    end
    if (b == 64'd0)                                                       r64 = rem ? a : '1;
    else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1)              r64 = rem ? 64'd0 : a;
    else if (sgn && rem)                                                  r64 = $signed(a) % $signed(b);
    else if (sgn)                                                         r64 = $signed(a) / $signed(b);
    else if (rem)                                                         r64 = a % b;
    else                                                                  r64 = a / b;
    return r64;
  endfunction

  function automatic bit is_special(input logic [63:0] a, b, input logic [2:0] f3, input logic w);
    bit sgn;
    sgn = ~f3[0];
    if (w) return (b[31:0] == 32'd0) || (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 64'd0) || (sgn && a == 64'h8000_0000_0000_0000 && b == '1);
  endfunction

  task automatic launch(input logic [63:0] a, b, input logic [2:0] f3, input logic w, output logic busy0);
    @(negedge clk);
    bus.StartE         = 1'b1;
    bus.ForwardedSrcAE = a;
    bus.ForwardedSrcBE = b;
    bus.Funct3E        = f3;
    bus.W64E           = w;
    #1 busy0 = bus.BusyE;
    @(posedge clk);
    #1 bus.StartE = 1'b0;
  endtask

  task automatic run_op(input logic [63:0] a, b, input logic [2:0] f3, input logic w, input string tag);
    logic [63:0] exp_r, res_at;
    int          exp_lat, done_cyc, busy_gap;
    logic        busy0;
    exp_r    = model(a, b, f3, w);
    exp_lat  = is_special(a, b, f3, w) ? 1 : (w ? 33 : 65);
    done_cyc = 0;
    busy_gap = 0;
    res_at   = 'x;
    launch(a, b, f3, w, busy0);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (bus.DoneE) begin
        done_cyc = c;
        res_at   = bus.DivResult;
        break;
      end
      if (!bus.BusyE) busy_gap++;
    end
    chk(64'(busy0), 64'd1, {tag, " busy_cycle0"});
    chk(64'(done_cyc), 64'(exp_lat), {tag, " done_latency"});
    chk(res_at, exp_r, {tag, " result"});
    chk(64'(busy_gap), 64'd0, {tag, " busy_gap"});
    @(negedge clk);
    chk({62'd0, bus.DoneE, bus.BusyE}, 64'd0, {tag, " idle_after"});
    last_res = exp_r;
  endtask

  function automatic logic [63:0] rand_opnd();
    logic [63:0] v;
    case ($urandom_range(0, 9))
      0:       v = 64'd0;
      1:       v = '1;
      2:       v = 64'h8000_0000_0000_0000;
      3:       v = 64'h0000_0000_8000_0000;
      4:       v = 64'($urandom_range(1, 20));
      default: v = {$urandom, $urandom} >> $urandom_range(0, 63);
    endcase
    if ($urandom_range(0, 3) == 0) v = -v;
    return v;
  endfunction

  initial begin
    logic busy0;
    int   stray;
    compared   = 0;
    mismatched = 0;
    last_res   = '0;
    reset              = 1'b1;
    bus.StartE         = 1'b0;
    bus.FlushE         = 1'b0;
    bus.ForwardedSrcAE = '0;
    bus.ForwardedSrcBE = '0;
    bus.Funct3E        = 3'b101;
    bus.W64E           = 1'b0;
    repeat (2) @(negedge clk);
    chk({62'd0, bus.BusyE, bus.DoneE}, 64'd0, "reset_flags");
    chk(bus.DivResult, 64'd0, "reset_result");
    reset = 1'b0;

    run_op(64'd100, 64'd7, 3'b101, 1'b0, "divu_100_7");
    run_op(64'd100, 64'd7, 3'b111, 1'b0, "remu_100_7");
    run_op(-64'd7, 64'd2, 3'b100, 1'b0, "div_m7_2");
    run_op(-64'd7, 64'd2, 3'b110, 1'b0, "rem_m7_2");
    run_op(64'd7, -64'd2, 3'b110, 1'b0, "rem_7_m2");
    run_op(64'd5, 64'd0, 3'b101, 1'b0, "divu_by0");
    run_op(64'd5, 64'd0, 3'b111, 1'b0, "remu_by0");
    run_op(64'h8000_0000_0000_0000, '1, 3'b100, 1'b0, "div_ovf");
    run_op(64'h0000_0000_8000_0000, '1, 3'b100, 1'b1, "divw_ovf");
    run_op(64'h1_0000_000A, 64'd3, 3'b101, 1'b1, "divuw_hi_ign");
    run_op(64'hFFFF_FFF9, 64'd2, 3'b110, 1'b1, "remw_m7_2");
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 3'b101, 1'b0, "divu_big_div");

    // flush during iteration 10
    launch(64'd1000, 64'd3, 3'b101, 1'b0, busy0);
    repeat (10) @(negedge clk);
    bus.FlushE = 1'b1;
    @(posedge clk);
    #1 bus.FlushE = 1'b0;
    @(negedge clk);
    chk({62'd0, bus.BusyE, bus.DoneE}, 64'd0, "flush_idle");
    chk(bus.DivResult, last_res, "flush_result_hold");
    run_op(64'd1000, 64'd3, 3'b111, 1'b0, "after_flush");

    // flush together with start: no launch
    @(negedge clk);
    bus.StartE = 1'b1;
    bus.FlushE = 1'b1;
    #1 chk(64'(bus.BusyE), 64'd0, "start_flush_busy");
    @(posedge clk);
    #1 bus.StartE = 1'b0;
    bus.FlushE = 1'b0;
    @(negedge clk);
    chk({62'd0, bus.BusyE, bus.DoneE}, 64'd0, "start_flush_nolaunch");

    // reset mid-BUSY
    run_op(64'd100, 64'd7, 3'b101, 1'b0, "pre_reset");
    launch(-64'd12345, 64'd17, 3'b100, 1'b0, busy0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk({62'd0, bus.BusyE, bus.DoneE}, 64'd0, "midreset_flags");
    chk(bus.DivResult, 64'd0, "midreset_result");
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    repeat (70) begin
      @(negedge clk);
      if (bus.DoneE || bus.BusyE) stray++;
    end
    chk(64'(stray), 64'd0, "midreset_no_done");

    for (int i = 0; i < 30; i++) begin
      run_op(rand_opnd(), rand_opnd(), 3'(3'b100 + 3'($urandom_range(0, 3))),
             1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
